// File: rtl/conv_pkg.sv
// Shared types and helpers for the 3x3 streaming convolution stage.
// Pixel/weight type, product/accumulator widths and int8 saturation.
package conv_pkg;
  localparam int KSIZE  = 3;
  localparam int NUM_W  = 9;
  localparam int PROD_W = 16;
  localparam int ACC_W  = 20;

  typedef logic signed [7:0]        pix_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  function automatic pix_t sat8(input acc_t v);
    if (v > acc_t'(127))
      return pix_t'(127);
    else if (v < acc_t'(-128))
      return pix_t'(-128);
    return v[7:0];
  endfunction
endpackage

// File: rtl/conv3x3_stream_if.sv
// Pixel stream, weight-load and result signals of conv3x3_stream.
// The master side drives pixels and weights; the slave side is the convolution stage.
interface conv3x3_stream_if;
  import conv_pkg::*;

  logic       in_valid;
  pix_t       in_data;
  logic       w_we;
  logic [3:0] w_addr;
  pix_t       w_data;
  logic       out_valid;
  pix_t       out_data;
  logic       out_last;

  modport master (
    output in_valid, in_data, w_we, w_addr, w_data,
    input  out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, w_we, w_addr, w_data,
    output out_valid, out_data, out_last
  );
endinterface

// File: rtl/conv_line_buf.sv
// Two-row line buffer: reads the column combinationally, then shifts the
// column down (row0 -> row1, din -> row0) on the write edge.
module conv_line_buf
  import conv_pkg::*;
#(
  parameter int W  = 28,
  parameter int CW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [CW-1:0] col,
  input  pix_t          din,
  output pix_t          row1_q,
  output pix_t          row0_q
);
  pix_t mem0 [W];
  pix_t mem1 [W];

  assign row0_q = mem0[col];
  assign row1_q = mem1[col];

  // Contents need no reset; writes are only blocked while reset is held.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem1[col] <= mem0[col];
      mem0[col] <= din;
    end
  end
endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 valid convolution with round/shift/saturate requantization.
// Define CONV_RELU_EN to clamp negative results to 0 after saturation.
module conv3x3_stream
  import conv_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int SHIFT = 7
) (
  input logic              clk,
  input logic              rst,
  conv3x3_stream_if.slave  bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam acc_t RND = acc_t'((1 << SHIFT) >> 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept;
  pix_t          lb_row1, lb_row0;

  pix_t  win  [NUM_W];
  pix_t  wgt  [NUM_W];
  prod_t prod [NUM_W];
  logic  v1, l1, v2, l2, v3, l3;
  acc_t  acc, sum_q, rounded, shifted;
  pix_t  res;

  assign accept = bus.in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  conv_line_buf #(.W(IMG_W), .CW(CW)) u_line_buf (
    .clk    (clk),
    .rst    (rst),
    .we     (accept),
    .col    (col),
    .din    (bus.in_data),
    .row1_q (lb_row1),
    .row0_q (lb_row0)
  );

  // Window index r*3+c; column 2 holds the newest pixel of each row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NUM_W; n++) win[n] <= '0;
      v1 <= 1'b0;
      l1 <= 1'b0;
    end else begin
      if (accept) begin
        for (int r = 0; r < KSIZE; r++) begin
          win[r*KSIZE]     <= win[r*KSIZE + 1];
          win[r*KSIZE + 1] <= win[r*KSIZE + 2];
        end
        win[2] <= lb_row1;
        win[5] <= lb_row0;
        win[8] <= bus.in_data;
      end
      v1 <= accept && (row >= RW'(2)) && (col >= CW'(2));
      l1 <= accept && (row == ROW_MAX) && (col == COL_MAX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NUM_W; n++) wgt[n] <= '0;
    end else if (bus.w_we && (bus.w_addr < 4'(NUM_W))) begin
      wgt[bus.w_addr] <= bus.w_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NUM_W; n++) prod[n] <= '0;
      v2 <= 1'b0;
      l2 <= 1'b0;
    end else begin
      for (int n = 0; n < NUM_W; n++) prod[n] <= prod_t'(win[n]) * prod_t'(wgt[n]);
      v2 <= v1;
      l2 <= l1;
    end
  end

  always_comb begin
    acc = '0;
    for (int n = 0; n < NUM_W; n++) acc = acc + acc_t'(prod[n]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      v3    <= 1'b0;
      l3    <= 1'b0;
    end else begin
      sum_q <= acc;
      v3    <= v2;
      l3    <= l2;
    end
  end

  always_comb begin
    rounded = sum_q + RND;
    shifted = rounded >>> SHIFT;
    res     = sat8(shifted);
`ifdef CONV_RELU_EN
    if (res < 0) res = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      bus.out_valid <= v3;
      bus.out_last  <= v3 && l3;
      if (v3) bus.out_data <= res;
    end
  end
endmodule

// File: tb/tb_conv3x3_stream.sv
// Self-checking bench for conv3x3_stream: three DUTs (SHIFT 0, 2, 7) share one
// stimulus stream and are compared against a direct convolution model.
module tb_conv3x3_stream;
  import conv_pkg::*;

  localparam int W    = 28;
  localparam int H    = 28;
  localparam int ND   = 3;
  localparam int MAXO = 16384;
  localparam int NPIX = W * H;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, w_we;
  logic [3:0] w_addr;
  logic signed [7:0] in_data, w_data;

  always #5 clk = ~clk;

  conv3x3_stream_if if0 ();
  conv3x3_stream_if if2 ();
  conv3x3_stream_if if7 ();

  assign if0.in_valid = in_valid; assign if0.in_data = in_data;
  assign if0.w_we = w_we; assign if0.w_addr = w_addr; assign if0.w_data = w_data;
  assign if2.in_valid = in_valid; assign if2.in_data = in_data;
  assign if2.w_we = w_we; assign if2.w_addr = w_addr; assign if2.w_data = w_data;
  assign if7.in_valid = in_valid; assign if7.in_data = in_data;
  assign if7.w_we = w_we; assign if7.w_addr = w_addr; assign if7.w_data = w_data;

  conv3x3_stream #(.IMG_W(W), .IMG_H(H), .SHIFT(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  conv3x3_stream #(.IMG_W(W), .IMG_H(H), .SHIFT(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
  conv3x3_stream #(.IMG_W(W), .IMG_H(H), .SHIFT(7)) dut7 (.clk(clk), .rst(rst), .bus(if7.slave));

  logic ov [ND];
  logic signed [7:0] odw [ND];
  logic olw [ND];
  assign ov[0] = if0.out_valid; assign odw[0] = if0.out_data; assign olw[0] = if0.out_last;
  assign ov[1] = if2.out_valid; assign odw[1] = if2.out_data; assign olw[1] = if2.out_last;
  assign ov[2] = if7.out_valid; assign odw[2] = if7.out_data; assign olw[2] = if7.out_last;

  int cyc = 0;
  int on [ND] = '{0, 0, 0};
  logic signed [7:0] od [ND][MAXO];
  logic ol [ND][MAXO];
  int ot [ND][MAXO];

  int ex_n;
  logic signed [7:0] ex_d [ND][MAXO];
  logic ex_l [MAXO];
  int ex_t [MAXO];
  int base [ND];

  int frames [2][H][W];
  int cur;
  int wt [9];
  int n_checks = 0;
  int n_pass   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int k = 0; k < ND; k++) begin
      if (ov[k]) begin
        if (on[k] < MAXO) begin
          od[k][on[k]] = odw[k];
          ol[k][on[k]] = olw[k];
          ot[k][on[k]] = cyc;
        end
        on[k] = on[k] + 1;
      end
    end
  end

  function automatic int sh_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 2 : 7;
  endfunction

  function automatic int requant(input int s, input int sh);
    int v;
    v = s;
    if (sh > 0) v = (s + (1 << (sh - 1))) >>> sh;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
`ifdef CONV_RELU_EN
    if (v < 0) v = 0;
`endif
    return v;
  endfunction

  function automatic int conv_at(input int r, input int c);
    int s;
    s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += wt[i*3 + j] * frames[cur][r-2+i][c-2+j];
    return s;
  endfunction

  task automatic start_capture();
    ex_n = 0;
    for (int k = 0; k < ND; k++) base[k] = on[k];
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic load_w();
    for (int n = 0; n < 16; n++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      w_we   = 1'b1;
      w_addr = 4'(n);
      w_data = (n < 9) ? 8'(wt[n]) : 8'($urandom_range(255));
    end
    @(posedge clk); #1;
    w_we = 1'b0;
  endtask

  task automatic fill_const(input int f, input int v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) frames[f][r][c] = v;
  endtask

  task automatic fill_rand(input int f);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) frames[f][r][c] = int'($urandom_range(255)) - 128;
  endtask

  task automatic rand_w();
    for (int n = 0; n < 9; n++) wt[n] = int'($urandom_range(255)) - 128;
  endtask

  task automatic send_frame(input int gap_pct, input int n_pix);
    int r, c, s;
    for (int p = 0; p < n_pix; p++) begin
      r = p / W;
      c = p % W;
      while (int'($urandom_range(99)) < gap_pct) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = 8'(frames[cur][r][c]);
      if (r >= 2 && c >= 2 && ex_n < MAXO) begin
        s = conv_at(r, c);
        for (int k = 0; k < ND; k++) ex_d[k][ex_n] = 8'(requant(s, sh_of(k)));
        ex_l[ex_n] = (r == H-1) && (c == W-1);
        ex_t[ex_n] = cyc + 1;
        ex_n++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    w_we = 1'b0; w_addr = '0; w_data = '0;
    repeat (3) @(posedge clk);
    #2;
    for (int k = 0; k < ND; k++) begin
      n_checks++;
      if ({ov[k], odw[k], olw[k]} !== 10'b0)
        $display("FAIL reset_outputs dut%0d: got v=%0b d=%0d l=%0b, want all 0", k, ov[k], odw[k], olw[k]);
      else n_pass++;
    end
    @(negedge clk); rst = 1'b0;
    // Weights are zero after reset, so every result must be zero.
    for (int n = 0; n < 9; n++) wt[n] = 0;
    cur = 0; fill_rand(0);
    start_capture();
    send_frame(0, NPIX);
    idle(6);
    for (int k = 0; k < ND; k++) begin
      n_checks++;
      if (on[k] - base[k] !== ex_n)
        $display("FAIL reset_wzero_count dut%0d: got %0d, want %0d", k, on[k] - base[k], ex_n);
      else n_pass++;
      for (int i = 0; i < ex_n && base[k] + i < MAXO; i++) begin
        n_checks++;
        if (od[k][base[k]+i] !== 8'sd0)
          $display("FAIL reset_wzero dut%0d idx %0d: got %0d, want 0", k, i, od[k][base[k]+i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_identity();
    for (int n = 0; n < 9; n++) wt[n] = (n == 4) ? 1 : 0;
    load_w();
    cur = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) frames[0][r][c] = (r*28 + c) % 100;
    start_capture();
    send_frame(0, NPIX);
    idle(6);
    n_checks++;
    if (ex_n !== 676) $display("FAIL identity_model_count: got %0d, want 676", ex_n);
    else n_pass++;
    for (int k = 0; k < ND; k++) begin
      n_checks++;
      if (on[k] - base[k] !== ex_n)
        $display("FAIL identity_count dut%0d: got %0d, want %0d", k, on[k] - base[k], ex_n);
      else n_pass++;
      for (int i = 0; i < ex_n && base[k] + i < MAXO; i++) begin
        n_checks++;
        if (od[k][base[k]+i] !== ex_d[k][i] || ol[k][base[k]+i] !== ex_l[i] || ot[k][base[k]+i] !== ex_t[i] + 3)
          $display("FAIL identity dut%0d idx %0d: got d=%0d l=%0b t=%0d, want d=%0d l=%0b t=%0d", k, i,
                   od[k][base[k]+i], ol[k][base[k]+i], ot[k][base[k]+i], ex_d[k][i], ex_l[i], ex_t[i] + 3);
        else n_pass++;
      end
    end
    n_checks++;
    if (od[0][base[0] + 675] !== 8'((27*28 + 27 - 29) % 100))
      $display("FAIL identity_last_value: got %0d, want %0d", od[0][base[0]+675], (26*28 + 26) % 100);
    else n_pass++;
  endtask

  task automatic test_const();
    int xs [4];
    int ws [4];
    int want0 [4];
    xs = '{10, 20, 5, -100};
    ws = '{1, 1, -1, -1};
`ifdef CONV_RELU_EN
    want0 = '{90, 127, 0, 127};
`else
    want0 = '{90, 127, -45, 127};
`endif
    for (int t = 0; t < 4; t++) begin
      for (int n = 0; n < 9; n++) wt[n] = ws[t];
      load_w();
      cur = 0; fill_const(0, xs[t]);
      start_capture();
      send_frame(0, NPIX);
      idle(6);
      n_checks++;
      if (od[0][base[0]] !== 8'(want0[t]))
        $display("FAIL const_sat case %0d: got %0d, want %0d", t, od[0][base[0]], want0[t]);
      else n_pass++;
      for (int k = 0; k < ND; k++) begin
        n_checks++;
        if (on[k] - base[k] !== ex_n)
          $display("FAIL const_count case %0d dut%0d: got %0d, want %0d", t, k, on[k] - base[k], ex_n);
        else n_pass++;
        for (int i = 0; i < ex_n && base[k] + i < MAXO; i++) begin
          n_checks++;
          if (od[k][base[k]+i] !== ex_d[k][i])
            $display("FAIL const case %0d dut%0d idx %0d: got %0d, want %0d", t, k, i, od[k][base[k]+i], ex_d[k][i]);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_rounding();
    int xs [3];
    int want2 [3];
    xs = '{6, 5, -6};
`ifdef CONV_RELU_EN
    want2 = '{2, 1, 0};
`else
    want2 = '{2, 1, -1};
`endif
    for (int n = 0; n < 9; n++) wt[n] = (n == 4) ? 1 : 0;
    load_w();
    for (int t = 0; t < 3; t++) begin
      cur = 0; fill_const(0, xs[t]);
      start_capture();
      send_frame(0, NPIX);
      idle(6);
      n_checks++;
      if (od[1][base[1] + 100] !== 8'(want2[t]))
        $display("FAIL round_shift2 input %0d: got %0d, want %0d", xs[t], od[1][base[1]+100], want2[t]);
      else n_pass++;
      for (int k = 0; k < ND; k++) begin
        n_checks++;
        if (on[k] - base[k] !== ex_n || od[k][base[k]] !== ex_d[k][0])
          $display("FAIL round dut%0d input %0d: got n=%0d d=%0d, want n=%0d d=%0d", k, xs[t],
                   on[k] - base[k], od[k][base[k]], ex_n, ex_d[k][0]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int gb [ND];
    int gn, diffs;
    rand_w(); load_w();
    fill_rand(0); fill_rand(1);
    start_capture();
    cur = 0; send_frame(0, NPIX);
    cur = 1; send_frame(0, NPIX);
    idle(6);
    for (int k = 0; k < ND; k++) gb[k] = base[k];
    gn = ex_n;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        start_capture();
        cur = 0; send_frame(50, NPIX);
        cur = 1; send_frame(50, NPIX);
        idle(6);
      end
      for (int k = 0; k < ND; k++) begin
        n_checks++;
        if (on[k] - base[k] !== ex_n)
          $display("FAIL b2b_count pass %0d dut%0d: got %0d, want %0d", pass, k, on[k] - base[k], ex_n);
        else n_pass++;
        for (int i = 0; i < ex_n && base[k] + i < MAXO; i++) begin
          n_checks++;
          if (od[k][base[k]+i] !== ex_d[k][i] || ol[k][base[k]+i] !== ex_l[i] || ot[k][base[k]+i] !== ex_t[i] + 3)
            $display("FAIL b2b pass %0d dut%0d idx %0d: got d=%0d l=%0b t=%0d, want d=%0d l=%0b t=%0d", pass, k, i,
                     od[k][base[k]+i], ol[k][base[k]+i], ot[k][base[k]+i], ex_d[k][i], ex_l[i], ex_t[i] + 3);
          else n_pass++;
        end
      end
    end
    for (int k = 0; k < ND; k++) begin
      diffs = 0;
      for (int i = 0; i < gn && base[k] + i < MAXO; i++)
        if (od[k][base[k]+i] !== od[k][gb[k]+i] || ol[k][base[k]+i] !== ol[k][gb[k]+i]) diffs++;
      n_checks++;
      if (diffs !== 0) $display("FAIL gap_vs_gapless dut%0d: got %0d differing outputs, want 0", k, diffs);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    rand_w(); load_w();
    cur = 0; fill_rand(0);
    start_capture();
    send_frame(0, 400);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    for (int k = 0; k < ND; k++) begin
      n_checks++;
      if ({ov[k], odw[k], olw[k]} !== 10'b0)
        $display("FAIL midreset_outputs dut%0d: got v=%0b d=%0d l=%0b, want all 0", k, ov[k], odw[k], olw[k]);
      else n_pass++;
    end
    start_capture();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    load_w();
    fill_rand(0);
    send_frame(0, NPIX);
    idle(6);
    for (int k = 0; k < ND; k++) begin
      n_checks++;
      if (on[k] - base[k] !== ex_n)
        $display("FAIL midreset_count dut%0d: got %0d, want %0d", k, on[k] - base[k], ex_n);
      else n_pass++;
      for (int i = 0; i < ex_n && base[k] + i < MAXO; i++) begin
        n_checks++;
        if (od[k][base[k]+i] !== ex_d[k][i] || ol[k][base[k]+i] !== ex_l[i] || ot[k][base[k]+i] !== ex_t[i] + 3)
          $display("FAIL midreset dut%0d idx %0d: got d=%0d l=%0b t=%0d, want d=%0d l=%0b t=%0d", k, i,
                   od[k][base[k]+i], ol[k][base[k]+i], ot[k][base[k]+i], ex_d[k][i], ex_l[i], ex_t[i] + 3);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_const();
    test_rounding();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
